// File: rtl/sisc_multicycle_core_if.sv
// Single-port memory bus between the SISC core (master) and its memory (slave).
// The transfer completes on the cycle where mem_req and mem_ack are both high.
interface sisc_multicycle_core_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/sisc_multicycle_core.sv
// Multicycle SISC CPU: FETCH/EXEC/MEMRD/MEMWR/ROT/WB/HALT over one req/ack memory port.
// Optional macro SISC_MUL_EN enables the MUL opcode; without it MUL traps as illegal.
module sisc_multicycle_core #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MAXREGS  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    sisc_multicycle_core_if.master        mem,
    output logic [ADDRSIZE-1:0]           pc,
    output logic [4:0]                    psr,
    output logic                          halted,
    output logic                          illegal
);
    localparam int RW = $clog2(MAXREGS);

    localparam logic [3:0] OP_NOP = 4'd0,  OP_BRA = 4'd1,  OP_LD  = 4'd2,  OP_STR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_MUL = 4'd6,  OP_CMP = 4'd7;
    localparam logic [3:0] OP_SHF = 4'd8,  OP_ROT = 4'd9,  OP_HLT = 4'd10, OP_MOV = 4'd11;

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC, S_MEMRD, S_MEMWR, S_ROT, S_WB, S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [4:0]          psr_q, psr_d;
    logic [31:0]         ir_q, ir_d;
    logic [WIDTH-1:0]    res_q, res_d, wdata_q, wdata_d;
    logic                carry_q, carry_d, rleft_q, rleft_d;
    logic                req_q, req_d, we_q, we_d, illegal_q, illegal_d;
    logic [11:0]         rcnt_q, rcnt_d;
    logic [WIDTH-1:0]    regs_q [MAXREGS];
    logic                rf_we;

    logic [3:0]          op, cc;
    logic                st, dt, br_take;
    logic [11:0]         src, dst, cnt_mag, rot_amt;
    logic [RW-1:0]       src_idx, dst_idx;
    logic [WIDTH-1:0]    imm, s_val, d_val, shf_res;
    logic [WIDTH:0]      sum, diff;

    assign op      = ir_q[31:28];
    assign st      = ir_q[27];
    assign dt      = ir_q[26];
    assign cc      = ir_q[27:24];
    assign src     = ir_q[23:12];
    assign dst     = ir_q[11:0];
    assign src_idx = src[RW-1:0];
    assign dst_idx = dst[RW-1:0];
    assign imm     = WIDTH'(src);
    assign s_val   = st ? imm : regs_q[src_idx];
    assign d_val   = regs_q[dst_idx];

    // src doubles as a signed shift/rotate count; negative means shift/rotate left
    assign cnt_mag = src[11] ? (~src + 12'd1) : src;
    assign rot_amt = 12'(32'(cnt_mag) % WIDTH);
    assign shf_res = (32'(cnt_mag) >= WIDTH) ? '0 :
                     (src[11] ? (d_val << cnt_mag) : (d_val >> cnt_mag));
    assign sum     = {1'b0, s_val} + {1'b0, d_val};
    assign diff    = {1'b0, s_val} - {1'b0, d_val};

`ifdef SISC_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, s_val} * {{WIDTH{1'b0}}, d_val};
`endif

    function automatic logic [4:0] flags_f(input logic [WIDTH-1:0] r, input logic c);
        return {r[WIDTH-1], (r == '0), ^r, ~r[0], c};
    endfunction

    always_comb begin
        case (cc)
            4'd0:    br_take = 1'b1;
            4'd1:    br_take = psr_q[0];
            4'd2:    br_take = psr_q[1];
            4'd3:    br_take = psr_q[2];
            4'd4:    br_take = psr_q[3];
            4'd5:    br_take = psr_q[4];
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        psr_d     = psr_q;
        ir_d      = ir_q;
        res_d     = res_q;
        carry_d   = carry_q;
        rcnt_d    = rcnt_q;
        rleft_d   = rleft_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        illegal_d = 1'b0;
        rf_we     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // right after reset no request is pending yet, so issue one
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + 1'b1;
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_NOP: ;
                    OP_BRA: if (br_take) pc_d = dst[ADDRSIZE-1:0];
                    OP_LD: begin
                        if (st) begin
                            res_d   = imm;
                            carry_d = 1'b0;
                            state_d = S_WB;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            addr_d  = src[ADDRSIZE-1:0];
                            state_d = S_MEMRD;
                        end
                    end
                    OP_STR: begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = dst[ADDRSIZE-1:0];
                        wdata_d = s_val;
                        state_d = S_MEMWR;
                    end
                    OP_MOV: begin
                        res_d   = s_val;
                        carry_d = 1'b0;
                        state_d = S_WB;
                    end
                    OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_SHF, OP_ROT: begin
                        if (dt) begin
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_WB;
                            carry_d = 1'b0;
                            case (op)
                                OP_ADD: begin res_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  end
                                OP_SUB: begin res_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
`ifdef SISC_MUL_EN
                                OP_MUL: begin
                                    res_d   = prod[WIDTH-1:0];
                                    carry_d = |prod[2*WIDTH-1:WIDTH];
                                end
`else
                                OP_MUL: begin
                                    illegal_d = 1'b1;
                                    state_d   = S_FETCH;
                                end
`endif
                                OP_CMP: res_d = ~s_val;
                                OP_SHF: res_d = shf_res;
                                default: begin
                                    res_d   = d_val;
                                    rcnt_d  = rot_amt;
                                    rleft_d = src[11];
                                    if (rot_amt != 12'd0) state_d = S_ROT;
                                end
                            endcase
                        end
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: illegal_d = 1'b1;
                endcase
                if (state_d == S_FETCH) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_d;
                end
            end
            S_MEMRD: begin
                if (mem.mem_ack) begin
                    res_d   = mem.mem_rdata;
                    carry_d = 1'b0;
                    req_d   = 1'b0;
                    state_d = S_WB;
                end
            end
            S_MEMWR: begin
                if (mem.mem_ack) begin
                    psr_d   = flags_f(wdata_q, 1'b0);
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_ROT: begin
                res_d  = rleft_q ? {res_q[WIDTH-2:0], res_q[WIDTH-1]}
                                 : {res_q[0], res_q[WIDTH-1:1]};
                rcnt_d = rcnt_q - 12'd1;
                if (rcnt_q == 12'd1) state_d = S_WB;
            end
            S_WB: begin
                rf_we   = 1'b1;
                psr_d   = flags_f(res_q, carry_q);
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_q;
                state_d = S_FETCH;
            end
            S_HALT: begin
                req_d = 1'b0;
                we_d  = 1'b0;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            psr_q     <= '0;
            ir_q      <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            rcnt_q    <= '0;
            rleft_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < MAXREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            psr_q     <= psr_d;
            ir_q      <= ir_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            rcnt_q    <= rcnt_d;
            rleft_q   <= rleft_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
            if (rf_we) regs_q[dst_idx] <= res_q;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc            = pc_q;
    assign psr           = psr_q;
    assign halted        = (state_q == S_HALT);
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_sisc_multicycle_core.sv
// Directed bench for sisc_multicycle_core: a table of instructions with expected psr,
// cycle count and stored memory values, plus hand sequences for wait states, branch and reset.
module tb_sisc_multicycle_core;
    localparam int WIDTH = 32, ADDRSIZE = 12, MAXREGS = 16, NPROG = 27;

`ifdef SISC_MUL_EN
    localparam logic [4:0]  P17 = 5'b00010;
    localparam int          C17 = 3;
    localparam int          NILL = 2;
    localparam logic [31:0] R5V = 32'h0000_2034;
    localparam logic [4:0]  P25 = 5'b00010;
`else
    localparam logic [4:0]  P17 = 5'b01011;
    localparam int          C17 = 2;
    localparam int          NILL = 3;
    localparam logic [31:0] R5V = 32'h0000_0ABC;
    localparam logic [4:0]  P25 = 5'b00110;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sisc_multicycle_core_if #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) mif();
    logic [ADDRSIZE-1:0] pc;
    logic [4:0]          psr;
    logic                halted, illegal;

    sisc_multicycle_core #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .MAXREGS(MAXREGS)) dut (
        .clk(clk), .reset(reset), .mem(mif), .pc(pc), .psr(psr), .halted(halted), .illegal(illegal)
    );

    // memory model with programmable ack wait
    logic [WIDTH-1:0] mem [4096];
    int ack_delay = 0;
    int wait_cnt;
    assign mif.mem_ack   = mif.mem_req && (wait_cnt >= ack_delay);
    assign mif.mem_rdata = mem[mif.mem_addr];
    always @(posedge clk) begin
        if (reset || !mif.mem_req || mif.mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (!reset && mif.mem_req && mif.mem_we && mif.mem_ack) mem[mif.mem_addr] = mif.mem_wdata;
    end

    // records each instruction fetch: cycle and psr at that moment
    int         cyc, ill_cnt;
    int         fetch_cyc [NPROG];
    logic [4:0] fetch_psr [NPROG];
    logic       fetch_seen [NPROG];
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            ill_cnt = 0;
            for (int i = 0; i < NPROG; i++) fetch_seen[i] = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (illegal) ill_cnt = ill_cnt + 1;
            if (mif.mem_req && mif.mem_ack && !mif.mem_we && int'(mif.mem_addr) < NPROG) begin
                fetch_cyc[mif.mem_addr]  = cyc;
                fetch_psr[mif.mem_addr]  = psr;
                fetch_seen[mif.mem_addr] = 1'b1;
            end
        end
    end

    int checks = 0, errors = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic st, input logic dt,
                                        input logic [11:0] src, input logic [11:0] dst);
        return {op, st, dt, 2'b00, src, dst};
    endfunction

    function automatic logic [31:0] bra(input logic [3:0] cc, input logic [11:0] dst);
        return {4'd1, cc, 12'h000, dst};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  psr;
        int          cyc;
        logic        mchk;
        logic [11:0] maddr;
        logic [31:0] mval;
    } vec_t;

    vec_t vt [NPROG-1];

    task automatic start(input int delay);
        reset = 1'b1;
        ack_delay = delay;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 4096; a++) mem[a] = '0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int t = 0;
        while (!halted && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, halted, 1'b1);
    endtask

    initial begin
        int  t, reqs;
        logic abort;

        vt[0]  = '{enc(4'd2, 1, 0, 12'd5,   12'd1), 5'b00000, 3, 0, 12'h0,   32'h0};
        vt[1]  = '{enc(4'd2, 1, 0, 12'd7,   12'd2), 5'b00100, 3, 0, 12'h0,   32'h0};
        vt[2]  = '{enc(4'd4, 0, 0, 12'd1,   12'd2), 5'b00010, 3, 0, 12'h0,   32'h0};
        vt[3]  = '{enc(4'd3, 0, 0, 12'd2, 12'h100), 5'b00010, 3, 1, 12'h100, 32'd12};
        vt[4]  = '{enc(4'd2, 1, 0, 12'd1,   12'd1), 5'b00100, 3, 0, 12'h0,   32'h0};
        vt[5]  = '{enc(4'd2, 1, 0, 12'd2,   12'd2), 5'b00110, 3, 0, 12'h0,   32'h0};
        vt[6]  = '{enc(4'd5, 0, 0, 12'd1,   12'd2), 5'b10001, 3, 0, 12'h0,   32'h0};
        vt[7]  = '{enc(4'd2, 0, 0, 12'h101, 12'd3), 5'b10000, 4, 0, 12'h0,   32'h0};
        vt[8]  = '{enc(4'd9, 0, 0, 12'hFFC, 12'd3), 5'b00010, 7, 0, 12'h0,   32'h0};
        vt[9]  = '{enc(4'd3, 0, 0, 12'd3, 12'h102), 5'b00010, 3, 1, 12'h102, 32'h18};
        vt[10] = '{enc(4'd7, 1, 0, 12'd0,   12'd4), 5'b10000, 3, 0, 12'h0,   32'h0};
        vt[11] = '{enc(4'd8, 0, 0, 12'h004, 12'd4), 5'b00000, 3, 0, 12'h0,   32'h0};
        vt[12] = '{enc(4'd8, 0, 0, 12'hFF8, 12'd4), 5'b10010, 3, 0, 12'h0,   32'h0};
        vt[13] = '{enc(4'd8, 0, 0, 12'h020, 12'd4), 5'b01010, 3, 0, 12'h0,   32'h0};
        vt[14] = '{enc(4'd11, 1, 0, 12'hABC, 12'd5), 5'b00110, 3, 0, 12'h0,  32'h0};
        vt[15] = '{bra(4'd4, 12'h020),              5'b00110, 2, 0, 12'h0,   32'h0};
        vt[16] = '{enc(4'd4, 1, 0, 12'd1,   12'd2), 5'b01011, 3, 0, 12'h0,   32'h0};
        vt[17] = '{enc(4'd6, 1, 0, 12'd3,   12'd5), P17,      C17, 0, 12'h0, 32'h0};
        vt[18] = '{enc(4'd4, 0, 1, 12'd1,   12'd2), P17,      2, 0, 12'h0,   32'h0};
        vt[19] = '{enc(4'd12, 0, 0, 12'd0,  12'd0), P17,      2, 0, 12'h0,   32'h0};
        vt[20] = '{enc(4'd3, 1, 0, 12'h5A5, 12'h103), 5'b00000, 3, 1, 12'h103, 32'h5A5};
        vt[21] = '{enc(4'd0, 0, 0, 12'd0,   12'd0), 5'b00000, 2, 0, 12'h0,   32'h0};
        vt[22] = '{enc(4'd9, 0, 0, 12'd0,   12'd1), 5'b00100, 3, 0, 12'h0,   32'h0};
        vt[23] = '{enc(4'd9, 0, 0, 12'd1,   12'd1), 5'b10110, 4, 0, 12'h0,   32'h0};
        vt[24] = '{enc(4'd3, 0, 0, 12'd1, 12'h104), 5'b10110, 3, 1, 12'h104, 32'h8000_0000};
        vt[25] = '{enc(4'd3, 0, 0, 12'd5, 12'h105), P25,      3, 1, 12'h105, R5V};

        // reset values while reset is held
        clear_mem();
        for (int i = 0; i < NPROG-1; i++) mem[i] = vt[i].instr;
        mem[NPROG-1] = enc(4'd10, 0, 0, 12'd0, 12'd0);
        mem[12'h101] = 32'h8000_0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_psr", psr, 0);
        check("rst_bus", {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
        check("rst_halted_illegal", {halted, illegal}, 0);

        // table program at zero-wait ack
        reset = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < NPROG-1 && !abort; i++) begin
            t = 0;
            while (!fetch_seen[i+1] && t < 40) begin
                @(posedge clk);
                t++;
            end
            if (!fetch_seen[i+1]) begin
                checks++;
                errors++;
                $display("FAIL v%0d_timeout: no fetch of next instruction within 40 cycles", i);
                abort = 1'b1;
            end else begin
                check($sformatf("v%0d_psr", i), fetch_psr[i+1], vt[i].psr);
                check($sformatf("v%0d_cycles", i), fetch_cyc[i+1] - fetch_cyc[i], vt[i].cyc);
                if (vt[i].mchk) check($sformatf("v%0d_mem", i), mem[vt[i].maddr], vt[i].mval);
            end
        end
        wait_halt("prog_halted", 20);
        check("prog_pc_after_hlt", pc, NPROG);
        check("prog_illegal_cycles", ill_cnt, NILL);
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mif.mem_req) reqs++;
        end
        check("halt_no_req", reqs, 0);
        check("halt_stays", halted, 1'b1);

        // delayed ack during fetch: request held, pc bumps once
        clear_mem();
        mem[0] = enc(4'd0, 0, 0, 12'd0, 12'd0);
        mem[1] = enc(4'd10, 0, 0, 12'd0, 12'd0);
        start(3);
        t = 0;
        while (!mif.mem_req && t < 10) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("wait%0d_req_ack_addr_pc", k),
                  {mif.mem_req, mif.mem_ack, mif.mem_we, mif.mem_addr, pc}, {3'b100, 12'h000, 12'h000});
        end
        @(negedge clk);
        check("wait_ack_addr", {mif.mem_req, mif.mem_ack, mif.mem_addr}, {2'b11, 12'h000});
        @(negedge clk);
        check("wait_pc_once", {mif.mem_req, pc}, {1'b0, 12'h001});
        wait_halt("wait_halted", 40);
        check("wait_pc_final", pc, 12'h002);

        // taken branch on ZERO
        clear_mem();
        mem[0]     = enc(4'd2, 1, 0, 12'd0, 12'd1);
        mem[1]     = bra(4'd4, 12'h020);
        mem[2]     = enc(4'd10, 0, 0, 12'd0, 12'd0);
        mem[12'h20] = enc(4'd10, 0, 0, 12'd0, 12'd0);
        start(0);
        wait_halt("bra_halted", 30);
        check("bra_taken_pc", pc, 12'h021);
        check("bra_psr", psr, 5'b01010);

        // reset while a data read is outstanding
        clear_mem();
        mem[0] = enc(4'd2, 1, 0, 12'd7, 12'd2);
        mem[1] = enc(4'd2, 0, 0, 12'h101, 12'd1);
        mem[12'h101] = 32'h1234_5678;
        start(4);
        t = 0;
        while (!(mif.mem_req && !mif.mem_we && mif.mem_addr == 12'h101) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("memrd_reached", {mif.mem_req, mif.mem_addr, psr}, {1'b1, 12'h101, 5'b00100});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort_req", mif.mem_req, 1'b0);
        check("rst_abort_pc_psr", {pc, psr}, 0);
        check("rst_abort_addr", mif.mem_addr, 0);
        reset = 1'b0;
        ack_delay = 0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
